// File: rtl/core_pkg.sv
// Shared constants for the core instruction decoder: inst field positions,
// phase encoding and sticky error bit indices.
package core_pkg;

   localparam int LEN_KIJ  = 9;
   localparam int LEN_ONIJ = 8;
   localparam int ADDR_W   = 11;
   localparam int INST_W   = 34;
   localparam int IDX_W    = 3;
   localparam int CNT_W    = 4;

   localparam int ACC_B    = 33;
   localparam int PCEN_B   = 32;
   localparam int PWEN_B   = 31;
   localparam int PADDR_HI = 30;
   localparam int PADDR_LO = 20;
   localparam int XCEN_B   = 19;
   localparam int XWEN_B   = 18;
   localparam int XADDR_HI = 17;
   localparam int XADDR_LO = 7;
   localparam int OFRD_B   = 6;
   localparam int RELU_B   = 5;
   localparam int IFRD_B   = 4;
   localparam int L0RD_B   = 3;
   localparam int L0WR_B   = 2;
   localparam int EXEC_B   = 1;
   localparam int LOAD_B   = 0;

   // Idle word: both SRAMs deselected (active-low strobes high), all else zero.
   localparam logic [INST_W-1:0] INST_IDLE = 34'h1800C0000;

   localparam int ERR_LDEX = 0;
   localparam int ERR_PWR  = 1;
   localparam int ERR_UFL  = 2;
   localparam int ERR_OVR  = 3;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_WLOAD = 2'd1,
      PH_EXEC  = 2'd2,
      PH_ACC   = 2'd3
   } phase_e;

endpackage

// File: rtl/core_ctrl_acc_tracker.sv
// Follows pmem reads into the SFP: aligns acc with read data, counts beats per
// output vector, flags finished vectors and catches truncated accumulations.
module core_ctrl_acc_tracker
   import core_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_pmem_cen,
   input  logic             i_pmem_wen,
   input  logic             i_acc,
   output logic             o_sfp_acc,
   output logic             o_sfp_clr,
   output logic             o_out_valid,
   output logic [IDX_W-1:0] o_out_idx,
   output logic             o_err_ovr
);

   logic             r_rd_vld;
   logic             r_acc_q;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_out_idx;
   logic             r_out_valid;
   logic             r_sfp_clr;
   logic             r_err_ovr;

   logic             w_sfp_acc;
   logic             w_full;
   logic             w_acc_fall;
   logic [IDX_W-1:0] w_idx_nxt;

   assign w_sfp_acc  = r_rd_vld & i_acc;
   assign w_full     = (r_cnt == CNT_W'(LEN_KIJ));
   assign w_acc_fall = r_acc_q & ~i_acc;
   assign w_idx_nxt  = (r_idx == IDX_W'(LEN_ONIJ - 1)) ? '0 : r_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_vld    <= 1'b0;
         r_acc_q     <= 1'b0;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
         r_sfp_clr   <= 1'b0;
         r_err_ovr   <= 1'b0;
      end else begin
         r_rd_vld    <= ~i_pmem_cen & i_pmem_wen;
         r_acc_q     <= i_acc;
         r_out_valid <= w_full;
         r_sfp_clr   <= r_out_valid;
         // A beat arriving in the flag cycle starts the next vector at 1.
         if (w_full) begin
            r_cnt     <= w_sfp_acc ? CNT_W'(1) : '0;
            r_out_idx <= r_idx;
            r_idx     <= w_idx_nxt;
         end else if (w_sfp_acc) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_acc_fall && (r_cnt != '0) && !w_full)
            r_err_ovr <= 1'b1;
      end
   end

   assign o_sfp_acc   = w_sfp_acc;
   assign o_sfp_clr   = r_sfp_clr;
   assign o_out_valid = r_out_valid;
   assign o_out_idx   = r_out_idx;
   assign o_err_ovr   = r_err_ovr;

endmodule

// File: rtl/core_ctrl.sv
// Instruction decoder and sequencing monitor: registers inst into SRAM strobes
// and datapath controls, tracks the operating phase and records protocol errors.
//
// state    | meaning
// PH_IDLE  | no load, execute or accumulate activity
// PH_WLOAD | weights moving into L0 (load or l0_wr)
// PH_EXEC  | array executing or OFIFO being drained
// PH_ACC   | SFP accumulating psums read from pmem
module core_ctrl
   import core_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [INST_W-1:0] inst,
   input  logic              ofifo_valid,
   output logic              xmem_cen,
   output logic              xmem_wen,
   output logic [ADDR_W-1:0] xmem_addr,
   output logic              pmem_cen,
   output logic              pmem_wen,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic              l0_wr,
   output logic              l0_rd,
   output logic              ififo_rd,
   output logic              ofifo_rd,
   output logic              load,
   output logic              execute,
   output logic              relu,
   output logic              sfp_acc,
   output logic              sfp_clr,
   output logic              out_valid,
   output logic [IDX_W-1:0]  out_idx,
   output logic [1:0]        phase,
   output logic [3:0]        err
);

   logic [INST_W-1:0] r_inst;
   logic [2:0]        r_err;
   phase_e            r_phase;
   phase_e            w_phase_nxt;
   logic              w_err_ovr;

   // Phase is decoded alongside the inst register so it lines up with the strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_inst  <= INST_IDLE;
         r_phase <= PH_IDLE;
      end else begin
         r_inst  <= inst;
         r_phase <= w_phase_nxt;
      end
   end

   always_comb begin
      w_phase_nxt = PH_IDLE;
      if (inst[ACC_B])
         w_phase_nxt = PH_ACC;
      else if (inst[EXEC_B] || inst[OFRD_B])
         w_phase_nxt = PH_EXEC;
      else if (inst[LOAD_B] || inst[L0WR_B])
         w_phase_nxt = PH_WLOAD;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= '0;
      end else begin
         if (r_inst[LOAD_B] && r_inst[EXEC_B])
            r_err[ERR_LDEX] <= 1'b1;
         if (r_inst[ACC_B] && !r_inst[PCEN_B] && !r_inst[PWEN_B])
            r_err[ERR_PWR] <= 1'b1;
         if (r_inst[OFRD_B] && !ofifo_valid)
            r_err[ERR_UFL] <= 1'b1;
      end
   end

   core_ctrl_acc_tracker u_acc_tracker (
      .clk         (clk),
      .rst_n       (reset),
      .i_pmem_cen  (r_inst[PCEN_B]),
      .i_pmem_wen  (r_inst[PWEN_B]),
      .i_acc       (r_inst[ACC_B]),
      .o_sfp_acc   (sfp_acc),
      .o_sfp_clr   (sfp_clr),
      .o_out_valid (out_valid),
      .o_out_idx   (out_idx),
      .o_err_ovr   (w_err_ovr)
   );

   assign xmem_cen  = r_inst[XCEN_B];
   assign xmem_wen  = r_inst[XWEN_B];
   assign xmem_addr = r_inst[XADDR_HI:XADDR_LO];
   assign pmem_cen  = r_inst[PCEN_B];
   assign pmem_wen  = r_inst[PWEN_B];
   assign pmem_addr = r_inst[PADDR_HI:PADDR_LO];
   assign l0_wr     = r_inst[L0WR_B];
   assign l0_rd     = r_inst[L0RD_B];
   assign ififo_rd  = r_inst[IFRD_B];
   assign ofifo_rd  = r_inst[OFRD_B];
   assign load      = r_inst[LOAD_B];
   assign execute   = r_inst[EXEC_B];
   assign relu      = r_inst[RELU_B];
   assign phase     = r_phase;
   assign err       = {w_err_ovr, r_err};

endmodule

// File: tb/tb_core_ctrl.sv
// Scenario bench for core_ctrl: decode latency, accumulation sequencing with a
// scoreboard of expected out_idx values, and sticky error detection.
module tb_core_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [33:0] inst = '1;
   logic        ofifo_valid = 1'b0;
   logic        xmem_cen, xmem_wen, pmem_cen, pmem_wen;
   logic [10:0] xmem_addr, pmem_addr;
   logic        l0_wr, l0_rd, ififo_rd, ofifo_rd, load, execute, relu;
   logic        sfp_acc, sfp_clr, out_valid;
   logic [2:0]  out_idx;
   logic [1:0]  phase;
   logic [3:0]  err;

   localparam logic [33:0] IDLE = 34'h1800C0000;

   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   logic [2:0]  exp_q[$];
   int          m_cnt = 0;
   int          m_idx = 0;
   logic        m_err3 = 1'b0;
   logic        prev_ov = 1'b0;

   core_ctrl dut (
      .clk(clk), .reset(reset), .inst(inst), .ofifo_valid(ofifo_valid),
      .xmem_cen(xmem_cen), .xmem_wen(xmem_wen), .xmem_addr(xmem_addr),
      .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
      .l0_wr(l0_wr), .l0_rd(l0_rd), .ififo_rd(ififo_rd), .ofifo_rd(ofifo_rd),
      .load(load), .execute(execute), .relu(relu),
      .sfp_acc(sfp_acc), .sfp_clr(sfp_clr), .out_valid(out_valid),
      .out_idx(out_idx), .phase(phase), .err(err)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: every out_valid pops one expected index.
   always @(negedge clk) begin
      if (reset) begin
         if (out_valid) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_valid_unexpected got idx=%0d, none expected", out_idx);
            end else begin
               logic [2:0] e;
               e = exp_q.pop_front();
               if (out_idx !== e) begin
                  errors++;
                  $display("FAIL out_idx got=%0d exp=%0d", out_idx, e);
               end
            end
         end
         if (prev_ov || sfp_clr) begin
            checks++;
            if (sfp_clr !== prev_ov) begin
               errors++;
               $display("FAIL sfp_clr got=%0b exp=%0b", sfp_clr, prev_ov);
            end
         end
         prev_ov <= out_valid;
      end else begin
         prev_ov <= 1'b0;
      end
   end

   task automatic step(input logic [33:0] v);
      @(posedge clk);
      #1 inst = v;
   endtask

   task automatic settle();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [33:0] rd_word(input int beat, input logic acc);
      logic [33:0] v;
      logic [10:0] a;
      v = IDLE;
      a = 11'((beat % 9) * 36);
      v[32] = 1'b0;
      v[30:20] = a;
      v[33] = acc;
      return v;
   endfunction

   task automatic model_beat();
      m_cnt++;
      if (m_cnt == 9) begin
         exp_q.push_back(3'(m_idx));
         m_idx = (m_idx + 1) % 8;
         m_cnt = 0;
      end
   endtask

   // Reads on slots 0..n-1, acc on slots 1..n so acc meets each read's data.
   task automatic drive_pass(input int nbeats, input bit drop_acc);
      logic [33:0] v;
      for (int t = 0; t <= nbeats; t++) begin
         v = (t < nbeats) ? rd_word(t, 1'b0) : IDLE;
         if (t > 0) begin
            v[33] = 1'b1;
            model_beat();
         end
         step(v);
      end
      if (drop_acc) begin
         step(IDLE);
         if (m_cnt != 0) m_err3 = 1'b1;
      end else begin
         v = IDLE;
         v[33] = 1'b1;
         step(v);
      end
   endtask

   task automatic drain(input string name);
      repeat (8) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending got=%0d outstanding exp=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      inst = '1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({xmem_cen, xmem_wen, pmem_cen, pmem_wen} !== 4'hF) begin
         errors++;
         $display("FAIL rst_strobes got=%h exp=f", {xmem_cen, xmem_wen, pmem_cen, pmem_wen});
      end
      checks++;
      if ({xmem_addr, pmem_addr} !== 22'd0) begin
         errors++;
         $display("FAIL rst_addr got=%h exp=0", {xmem_addr, pmem_addr});
      end
      checks++;
      if ({l0_wr, l0_rd, ififo_rd, ofifo_rd, load, execute, relu, sfp_acc, sfp_clr, out_valid} !== 10'd0) begin
         errors++;
         $display("FAIL rst_ctrl got=%b exp=0",
                  {l0_wr, l0_rd, ififo_rd, ofifo_rd, load, execute, relu, sfp_acc, sfp_clr, out_valid});
      end
      checks++;
      if ({out_idx, phase, err} !== 9'd0) begin
         errors++;
         $display("FAIL rst_state got idx=%0d phase=%0d err=%h exp=0", out_idx, phase, err);
      end
      inst = IDLE;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({xmem_cen, pmem_cen, phase} !== 4'b1100) begin
         errors++;
         $display("FAIL rel_idle got xcen=%b pcen=%b phase=%0d exp=1 1 0", xmem_cen, pmem_cen, phase);
      end
   endtask

   task automatic test_decode();
      logic [33:0] v;
      ofifo_valid = 1'b1;
      v = IDLE;
      v[19] = 1'b0;
      v[18] = 1'b0;
      v[17:7] = 11'h400;
      step(v);
      settle();
      checks++;
      if ({xmem_cen, xmem_wen, xmem_addr, phase} !== {2'b00, 11'h400, 2'd0}) begin
         errors++;
         $display("FAIL dec_xmem got cen=%b wen=%b addr=%h phase=%0d exp=0 0 400 0",
                  xmem_cen, xmem_wen, xmem_addr, phase);
      end
      v = IDLE;
      v[32] = 1'b0;
      v[31] = 1'b0;
      v[30:20] = 11'h7FF;
      v[5] = 1'b1;
      v[4] = 1'b1;
      v[3] = 1'b1;
      v[2] = 1'b1;
      step(v);
      settle();
      checks++;
      if ({pmem_cen, pmem_wen, pmem_addr, relu, ififo_rd, l0_rd, l0_wr, phase} !==
          {2'b00, 11'h7FF, 4'hF, 2'd1}) begin
         errors++;
         $display("FAIL dec_wload got pcen=%b pwen=%b addr=%h ctl=%b phase=%0d exp=0 0 7ff 1111 1",
                  pmem_cen, pmem_wen, pmem_addr, {relu, ififo_rd, l0_rd, l0_wr}, phase);
      end
      v = IDLE;
      v[6] = 1'b1;
      v[1] = 1'b1;
      step(v);
      settle();
      checks++;
      if ({ofifo_rd, execute, load, phase} !== {3'b110, 2'd2}) begin
         errors++;
         $display("FAIL dec_exec got ofrd=%b ex=%b ld=%b phase=%0d exp=1 1 0 2",
                  ofifo_rd, execute, load, phase);
      end
      v = IDLE;
      v[33] = 1'b1;
      v[0] = 1'b1;
      v[1] = 1'b0;
      step(v);
      settle();
      checks++;
      if ({load, phase} !== {1'b1, 2'd3}) begin
         errors++;
         $display("FAIL dec_acc_prio got ld=%b phase=%0d exp=1 3", load, phase);
      end
      step(IDLE);
      repeat (3) @(negedge clk);
      checks++;
      if (err !== 4'h0) begin
         errors++;
         $display("FAIL dec_err got=%h exp=0", err);
      end
   endtask

   task automatic test_accum();
      int p0;
      p0 = pulses;
      drive_pass(72, 1'b1);
      drive_pass(9, 1'b1);
      drain("accum");
      checks++;
      if (pulses - p0 != 9) begin
         errors++;
         $display("FAIL accum_pulses got=%0d exp=9", pulses - p0);
      end
      checks++;
      if (err !== 4'h0) begin
         errors++;
         $display("FAIL accum_err got=%h exp=0", err);
      end
   endtask

   task automatic test_short();
      int p0;
      p0 = pulses;
      drive_pass(5, 1'b1);
      drain("short");
      checks++;
      if (pulses != p0 || err[3] !== 1'b1 || m_err3 !== 1'b1) begin
         errors++;
         $display("FAIL short got pulses=%0d err3=%b exp=0 1", pulses - p0, err[3]);
      end
      drive_pass(9, 1'b1);
      drain("short_after");
      checks++;
      if (err[3] !== m_err3) begin
         errors++;
         $display("FAIL short_sticky got err3=%b exp=%b", err[3], m_err3);
      end
   endtask

   task automatic test_underflow();
      logic [33:0] v;
      ofifo_valid = 1'b0;
      v = IDLE;
      v[6] = 1'b1;
      step(v);
      settle();
      checks++;
      if (ofifo_rd !== 1'b1) begin
         errors++;
         $display("FAIL ufl_passthru got ofifo_rd=%b exp=1", ofifo_rd);
      end
      v = IDLE;
      v[0] = 1'b1;
      v[1] = 1'b1;
      step(v);
      step(IDLE);
      repeat (3) @(negedge clk);
      checks++;
      if (err !== {m_err3, 3'b101}) begin
         errors++;
         $display("FAIL ufl_err got=%b exp=%b", err, {m_err3, 3'b101});
      end
      v = IDLE;
      v[33] = 1'b1;
      v[32] = 1'b0;
      v[31] = 1'b0;
      step(v);
      step(IDLE);
      if (m_cnt != 0) m_err3 = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (err !== {m_err3, 3'b111}) begin
         errors++;
         $display("FAIL pwr_err got=%b exp=%b", err, {m_err3, 3'b111});
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      inst = IDLE;
      exp_q.delete();
      m_cnt = 0;
      m_idx = 0;
      m_err3 = 1'b0;
      #1;
      checks++;
      if ({out_idx, err, out_valid} !== 8'd0) begin
         errors++;
         $display("FAIL reset_async got idx=%0d err=%h ov=%b exp=0", out_idx, err, out_valid);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_midreset();
      int p0;
      do_reset();
      drive_pass(31, 1'b0);
      drain("mid_pre");
      do_reset();
      p0 = pulses;
      drive_pass(9, 1'b1);
      drain("mid_post");
      checks++;
      if (pulses - p0 != 1 || err !== 4'h0) begin
         errors++;
         $display("FAIL mid_fresh got pulses=%0d err=%h exp=1 0", pulses - p0, err);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_accum();
      test_short();
      test_underflow();
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Instruction decoder and sequencing monitor inside `core`, i.e. the responder for the 34-bit `inst` word the host or bench issues each cycle.
- Registers and decodes `inst` into xmem/pmem SRAM strobes and L0/IFIFO/OFIFO/array/SFP controls, aligned to the SRAM 1-cycle read latency.
- Counts accumulation beats and flags each finished output vector.
- Detects protocol violations and records them in sticky error bits.

Parameters:
- LEN_KIJ, 9, accumulation beats per output vector
- LEN_ONIJ, 8, output vectors per accumulation pass; out_idx wraps after this
- ADDR_W, 11, SRAM address width
- INST_W, 34, instruction width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- inst  in  34  instruction word: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] relu, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- ofifo_valid  in  1  OFIFO has a full row available
- xmem_cen, xmem_wen  out  1 each  activation/weight SRAM strobes, active-low
- xmem_addr  out  ADDR_W  activation/weight SRAM address
- pmem_cen, pmem_wen  out  1 each  psum SRAM strobes, active-low
- pmem_addr  out  ADDR_W  psum SRAM address
- l0_wr, l0_rd, ififo_rd, ofifo_rd, load, execute, relu  out  1 each  registered control bits
- sfp_acc  out  1  SFP adds the current pmem read data
- sfp_clr  out  1  one-cycle clear of the SFP accumulator
- out_valid  out  1  one-cycle pulse: sfp_out holds a complete vector
- out_idx  out  3  index of the vector flagged by out_valid
- phase  out  2  0 IDLE, 1 WLOAD, 2 EXEC, 3 ACC
- err  out  4  sticky: [0] load&execute, [1] pmem write during acc, [2] ofifo underflow, [3] acc overrun

Behaviour:
- Reset (reset=0, async) values:
  - cen/wen outputs = 1; addresses = 0.
  - All control bits, sfp_acc, sfp_clr, out_valid = 0.
  - out_idx = 0; phase = IDLE; err = 0; internal counters = 0.
- Stage 1: inst is registered every cycle. All SRAM/control outputs come straight from this register, so output latency is exactly 1 cycle from inst.
- rd_vld is a registered flag: pmem_cen==0 && pmem_wen==1 in the previous cycle.
  - sfp_acc = rd_vld && acc bit of the registered inst. Data and acc are therefore aligned 2 cycles after the inst that issued the read.
- acc_cnt increments on each sfp_acc cycle.
  - When acc_cnt reaches LEN_KIJ, out_valid pulses the next cycle with the current out_idx.
  - That same cycle acc_cnt clears, out_idx increments (wraps LEN_ONIJ-1 → 0), and sfp_clr pulses one cycle later.
- An sfp_acc while acc_cnt==LEN_KIJ (no gap before the next vector) is legal. The count restarts at 1 for that beat.
- acc falling with 0 < acc_cnt < LEN_KIJ: no out_valid, acc_cnt held, err[3] set.
- Phase FSM, evaluated on the registered inst; priority ACC > EXEC > WLOAD > IDLE:
  - ACC: acc=1.
  - EXEC: execute=1 or ofifo_rd=1.
  - WLOAD: load=1 or l0_wr=1.
  - IDLE: otherwise.
- Error conditions:
  - err[0]: load and execute both 1.
  - err[1]: acc=1 while pmem_cen=0 and pmem_wen=0.
  - err[2]: ofifo_rd=1 while ofifo_valid=0. Outputs still pass through unchanged.
  - Errors are recorded only; decoding is never blocked. err clears only on reset.
- Simultaneous out_valid and a new sfp_acc in the same cycle: both are honoured.
- Reset mid-accumulation discards partial counts and clears out_idx.

Decomposition:
- Package core_pkg: inst bit-position constants (ACC_B=33 … LOAD_B=0), phase enum, err bit indices.
- One sub-module, acc_tracker: contains rd_vld, acc_cnt, out_idx, out_valid, sfp_clr and err[3]. The top level holds the decode register, phase FSM and err[2:0].

Test Plan:
- Reset release: hold reset=0, drive inst=all-ones → all outputs at reset values; after release, xmem_cen=1 and pmem_cen=1 until a strobe is issued.
- Decode latency: inst with CEN_xmem=0, WEN_xmem=0, A_xmem=0x400 → next cycle xmem_cen=0, xmem_wen=0, xmem_addr=0x400, phase=IDLE.
- Accumulation: issue 9 pmem reads, addresses 0,36,72…, with acc asserted one cycle later; repeat 8 vectors back-to-back → 8 out_valid pulses with out_idx 0..7, then wrap to 0; err=0.
- Short accumulation: 5 beats, then acc=0 → no out_valid, err[3]=1, and it stays set through later valid passes.
- Underflow: ofifo_rd=1 with ofifo_valid=0 → err[2]=1 and ofifo_rd output still 1; load=1 with execute=1 → err[0]=1.
- Mid-op reset: assert reset at beat 4 of vector 3 → out_idx=0 and acc_cnt=0; a fresh 9-beat pass then yields out_valid with out_idx=0.
